// File: rtl/vregm_pkg.sv
// Shared types and helpers for the vector register file slice.
package vregm_pkg;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_NREGS = 16;
  localparam int DEF_NREAD = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Low bit of lane 'lane' inside a packed LANES*XLEN word
  function automatic int lane_lo(input int lane, input int xlen);
    return lane * xlen;
  endfunction

endpackage

// File: rtl/vregm_clear_seq.sv
// Post-reset clear sequencer: sweeps every register address once, then holds READY.
// One address per cycle, NREGS cycles after reset release; no backpressure.
module vregm_clear_seq
  import vregm_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_ready,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t        r_state;
  logic [AW:0]   r_clr_idx;
  logic          r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_idx <= r_clr_idx + ONE;
          if (r_clr_idx == LAST_IDX) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: r_ready <= 1'b1;
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_clr_idx[AW-1:0];

endmodule

// File: rtl/vregm.sv
// Multi-lane vector register file with write-through bypass, busy scoreboard and post-reset clear.
// Reads are combinational (0 cycles), writes land at the next edge; ports ignored until o_ready.
module vregm
  import vregm_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int LANES    = DEF_LANES,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(NREGS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NREAD*AW-1:0]         i_rd_addr,
  output logic [NREAD*LANES*XLEN-1:0] o_rd_data,
  output logic [NREAD-1:0]            o_rd_busy,
  input  logic                        i_wr_en,
  input  logic [AW-1:0]               i_wr_addr,
  input  logic [LANES-1:0]            i_wr_mask,
  input  logic [LANES*XLEN-1:0]       i_wr_data,
  input  logic                        i_wr_last,
  input  logic                        i_iss_en,
  input  logic [AW-1:0]               i_iss_addr,
  output logic                        o_ready
);

  localparam int  RW = LANES * XLEN;
  localparam bit  ZR = (ZERO_REG != 0);

  logic [RW-1:0]    r_mem [NREGS];
  logic [NREGS-1:0] r_busy;

  logic             w_ready;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_port_we;
  logic             w_iss_ok;

  vregm_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_port_we = w_ready && i_wr_en && !(ZR && (i_wr_addr == '0));
  assign w_iss_ok  = w_ready && i_iss_en && !(ZR && (i_iss_addr == '0));

  // Clear sweep owns the array until ready, so the two writers never collide
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_port_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_wr_mask[l]) begin
          r_mem[i_wr_addr][lane_lo(l, XLEN) +: XLEN] <= i_wr_data[lane_lo(l, XLEN) +: XLEN];
        end
      end
    end
  end

  // Issue is applied after the clear so a same-cycle set wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else if (w_ready) begin
      if (i_wr_en && i_wr_last) r_busy[i_wr_addr] <= 1'b0;
      if (w_iss_ok)             r_busy[i_iss_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_hit;

    assign w_ra   = i_rd_addr[p*AW +: AW];
    assign w_zero = ZR && (w_ra == '0);
    assign w_hit  = i_wr_en && (i_wr_addr == w_ra);

    for (genvar l = 0; l < LANES; l++) begin : g_ln
      assign o_rd_data[p*RW + l*XLEN +: XLEN] =
        (!w_ready || w_zero)       ? '0 :
        (w_hit && i_wr_mask[l])    ? i_wr_data[l*XLEN +: XLEN] :
                                     r_mem[w_ra][l*XLEN +: XLEN];
    end

    assign o_rd_busy[p] = w_ready && !w_zero && r_busy[w_ra] && !(w_hit && i_wr_last);
  end

  assign o_ready = w_ready;

endmodule

// File: tb/tb_vregm.sv
// Directed bench for vregm: default configuration plus a narrow 3-port configuration.
module tb_vregm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: XLEN=32, LANES=4, NREGS=16, NREAD=2
  logic         a_rst = 1'b1;
  logic [7:0]   a_rd_addr = '0;
  logic [255:0] a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_wr_en = 1'b0;
  logic [3:0]   a_wr_addr = '0;
  logic [3:0]   a_wr_mask = '0;
  logic [127:0] a_wr_data = '0;
  logic         a_wr_last = 1'b0;
  logic         a_iss_en = 1'b0;
  logic [3:0]   a_iss_addr = '0;
  logic         a_ready;

  // Narrow configuration: XLEN=8, LANES=2, NREGS=8, NREAD=3
  logic         b_rst = 1'b1;
  logic [8:0]   b_rd_addr = '0;
  logic [47:0]  b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_wr_en = 1'b0;
  logic [2:0]   b_wr_addr = '0;
  logic [1:0]   b_wr_mask = '0;
  logic [15:0]  b_wr_data = '0;
  logic         b_wr_last = 1'b0;
  logic         b_iss_en = 1'b0;
  logic [2:0]   b_iss_addr = '0;
  logic         b_ready;

  vregm #(.XLEN(32), .LANES(4), .NREGS(16), .NREAD(2), .ZERO_REG(1)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
    .o_rd_busy(a_rd_busy), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr),
    .i_wr_mask(a_wr_mask), .i_wr_data(a_wr_data), .i_wr_last(a_wr_last),
    .i_iss_en(a_iss_en), .i_iss_addr(a_iss_addr), .o_ready(a_ready)
  );

  vregm #(.XLEN(8), .LANES(2), .NREGS(8), .NREAD(3), .ZERO_REG(1)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .o_rd_busy(b_rd_busy), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
    .i_wr_mask(b_wr_mask), .i_wr_data(b_wr_data), .i_wr_last(b_wr_last),
    .i_iss_en(b_iss_en), .i_iss_addr(b_iss_addr), .o_ready(b_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         we;
    logic [3:0]   wa;
    logic [3:0]   wm;
    logic [127:0] wd;
    logic         wl;
    logic         ie;
    logic [3:0]   ia;
    logic [3:0]   ra0;
    logic [3:0]   ra1;
    logic [127:0] e0;
    logic [127:0] e1;
    logic [1:0]   eb;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [3:0] wm,
                              input logic [127:0] wd, input logic wl, input logic ie,
                              input logic [3:0] ia, input logic [3:0] ra0, input logic [3:0] ra1,
                              input logic [127:0] e0, input logic [127:0] e1, input logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wm = wm; v.wd = wd; v.wl = wl; v.ie = ie; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  localparam logic [31:0]  DA = 32'hAAAA_0000, DB = 32'hBBBB_0001, DC = 32'hCCCC_0002, DD = 32'hDDDD_0003;
  localparam logic [31:0]  DE = 32'hEEEE_0004, DF = 32'hFFFF_0005, DG = 32'h6666_0006, DH = 32'h7777_0007;
  localparam logic [127:0] R3   = {4{32'hA5A5_0003}};
  localparam logic [127:0] R5A  = {DD, DC, DB, DA};
  localparam logic [127:0] R5W  = {DH, DG, DF, DE};
  localparam logic [127:0] R5   = {DD, DG, DB, DE};
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] VX   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] VY   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] VZ   = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_9BDF;

  vec_t tbl[17];
  int   cnt;

  initial begin
    tbl[0]  = mk(1, 3, 4'hF, R3,  0, 0, 0, 3, 3, R3,  R3,  2'b00);
    tbl[1]  = mk(0, 0, 4'h0, '0,  0, 0, 0, 3, 3, R3,  R3,  2'b00);
    tbl[2]  = mk(1, 5, 4'hF, R5A, 0, 0, 0, 5, 3, R5A, R3,  2'b00);
    tbl[3]  = mk(1, 5, 4'h5, R5W, 0, 0, 0, 5, 5, R5,  R5,  2'b00);
    tbl[4]  = mk(0, 0, 4'h0, '0,  0, 0, 0, 5, 0, R5,  '0,  2'b00);
    tbl[5]  = mk(1, 0, 4'hF, ONES,0, 0, 0, 0, 0, '0,  '0,  2'b00);
    tbl[6]  = mk(0, 0, 4'h0, '0,  0, 1, 0, 0, 5, '0,  R5,  2'b00);
    tbl[7]  = mk(0, 0, 4'h0, '0,  0, 0, 0, 0, 0, '0,  '0,  2'b00);
    tbl[8]  = mk(0, 0, 4'h0, '0,  0, 1, 7, 7, 3, '0,  R3,  2'b00);
    tbl[9]  = mk(0, 0, 4'h0, '0,  0, 0, 0, 7, 7, '0,  '0,  2'b11);
    tbl[10] = mk(1, 7, 4'hF, VX,  0, 0, 0, 7, 7, VX,  VX,  2'b11);
    tbl[11] = mk(1, 7, 4'h0, VY,  1, 0, 0, 7, 7, VX,  VX,  2'b00);
    tbl[12] = mk(0, 0, 4'h0, '0,  0, 0, 0, 7, 3, VX,  R3,  2'b00);
    tbl[13] = mk(1, 7, 4'h0, VY,  1, 1, 7, 7, 7, VX,  VX,  2'b00);
    tbl[14] = mk(0, 0, 4'h0, '0,  0, 0, 0, 7, 7, VX,  VX,  2'b11);
    tbl[15] = mk(1, 7, 4'hF, VZ,  1, 0, 0, 7, 5, VZ,  R5,  2'b00);
    tbl[16] = mk(0, 0, 4'h0, '0,  0, 0, 0, 7, 7, VZ,  VZ,  2'b00);

    // Reset state and clear length, default configuration
    a_rd_addr = {4'd5, 4'd3};
    tick; tick;
    chk("a_rst_ready", 256'(a_ready), 256'(0));
    chk("a_rst_data", a_rd_data, '0);
    chk("a_rst_busy", 256'(a_rd_busy), 256'(0));
    a_rst = 1'b0;
    cnt = 0;
    while (!a_ready && cnt < 40) begin tick; cnt++; end
    chk("a_clear_len", 256'(cnt), 256'(16));
    for (int r = 0; r < 16; r++) begin
      a_rd_addr = {4'(15 - r), 4'(r)};
      #1;
      chk("a_post_clear_data", a_rd_data, '0);
    end

    // Cycle-by-cycle table: write, partial-mask bypass, zero register, busy scoreboard
    for (int i = 0; i < 17; i++) begin
      a_wr_en = tbl[i].we; a_wr_addr = tbl[i].wa; a_wr_mask = tbl[i].wm;
      a_wr_data = tbl[i].wd; a_wr_last = tbl[i].wl;
      a_iss_en = tbl[i].ie; a_iss_addr = tbl[i].ia;
      a_rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("a_vec%0d_rd0", i), 256'(a_rd_data[127:0]), 256'(tbl[i].e0));
      chk($sformatf("a_vec%0d_rd1", i), 256'(a_rd_data[255:128]), 256'(tbl[i].e1));
      chk($sformatf("a_vec%0d_busy", i), 256'(a_rd_busy), 256'(tbl[i].eb));
      chk($sformatf("a_vec%0d_ready", i), 256'(a_ready), 256'(1));
      tick;
    end

    // Reset mid-clear after prior writes and an outstanding busy register
    a_wr_en = 1'b0; a_iss_en = 1'b1; a_iss_addr = 4'd9;
    tick;
    a_iss_en = 1'b0; a_rd_addr = {4'd9, 4'd9};
    #1;
    chk("a_busy_r9_before_rst", 256'(a_rd_busy), 256'(2'b11));
    a_rst = 1'b1;
    #1;
    chk("a_async_rst_ready", 256'(a_ready), 256'(0));
    chk("a_async_rst_busy", 256'(a_rd_busy), 256'(0));
    tick;
    a_rst = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 4'd15; a_wr_mask = 4'hF; a_wr_data = ONES; a_wr_last = 1'b1;
    a_iss_en = 1'b1; a_iss_addr = 4'd9;
    a_rd_addr = {4'd5, 4'd3};
    repeat (5) tick;
    chk("a_midclear_ready", 256'(a_ready), 256'(0));
    chk("a_midclear_data", a_rd_data, '0);
    chk("a_midclear_busy", 256'(a_rd_busy), 256'(0));
    a_rst = 1'b1;
    tick;
    a_rst = 1'b0;
    cnt = 0;
    while (!a_ready && cnt < 40) begin tick; cnt++; end
    chk("a_reclear_len", 256'(cnt), 256'(16));
    a_wr_en = 1'b0; a_iss_en = 1'b0; a_wr_last = 1'b0;
    for (int r = 0; r < 16; r++) begin
      a_rd_addr = {4'(15 - r), 4'(r)};
      #1;
      chk("a_reclear_data", a_rd_data, '0);
      chk("a_reclear_busy", 256'(a_rd_busy), 256'(0));
    end

    // Narrow configuration: clear length, full write, partial-mask bypass on 3 ports
    tick;
    b_rst = 1'b0;
    cnt = 0;
    while (!b_ready && cnt < 40) begin tick; cnt++; end
    chk("b_clear_len", 256'(cnt), 256'(8));
    for (int r = 0; r < 8; r++) begin
      b_rd_addr = {3'(r), 3'(r), 3'(r)};
      #1;
      chk("b_post_clear_data", 256'(b_rd_data), 256'(0));
      chk("b_post_clear_busy", 256'(b_rd_busy), 256'(0));
    end
    b_wr_en = 1'b1; b_wr_addr = 3'd3; b_wr_mask = 2'b11; b_wr_data = 16'hA503;
    tick;
    b_wr_en = 1'b0; b_rd_addr = {3'd3, 3'd3, 3'd3};
    #1;
    chk("b_r3_read", 256'(b_rd_data), 256'({3{16'hA503}}));
    b_wr_en = 1'b1; b_wr_addr = 3'd5; b_wr_mask = 2'b11; b_wr_data = 16'h2211;
    tick;
    b_wr_mask = 2'b01; b_wr_data = 16'h4433; b_rd_addr = {3'd5, 3'd5, 3'd5};
    #1;
    chk("b_r5_bypass", 256'(b_rd_data), 256'({3{16'h2233}}));
    tick;
    b_wr_en = 1'b0;
    #1;
    chk("b_r5_stored", 256'(b_rd_data), 256'({3{16'h2233}}));
    chk("b_r5_busy", 256'(b_rd_busy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
